// File: rtl/transmissor_16_pkg.sv
// rtl/transmissor_16_pkg.sv - shared state encoding, bit timing and frame length constants for transmissor_16
package transmissor_16_pkg;

    // Debug encoding: db_estado shows these values 0..7 in declaration order.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_PAR   = 3'd4,
        ST_STOP  = 3'd5,
        ST_NEXT  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    localparam int FRAME_BITS_PAR    = 11;
    localparam int FRAME_BITS_NO_PAR = 10;

    function automatic int bit_ticks(input int clock_hz, input int baud_rate);
        return clock_hz / baud_rate;
    endfunction

    function automatic int frame_bits(input int parity);
        return (parity != 0) ? FRAME_BITS_PAR : FRAME_BITS_NO_PAR;
    endfunction

endpackage

// File: rtl/tx_serial_8.sv
// rtl/tx_serial_8.sv - single-byte serial frame sender (start, 8 data bits LSB first, optional even parity, stop)
module tx_serial_8
    import transmissor_16_pkg::*;
#(
    parameter int TICKS  = 434,
    parameter int PARITY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx_serial,
    output logic       fim,
    output state_t     phase_next
);

    localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);

    state_t            phase;
    logic [TICK_W-1:0] tick;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              par_q;
    logic              tick_last;
    logic              load;

    assign tick_last = (tick == TICK_LAST);

    // fim marks the last cycle of the stop bit, so a start seen here chains
    // the next frame without any idle cycle on the line.
    assign fim  = (phase == ST_STOP) && tick_last;
    assign load = start && ((phase == ST_IDLE) || fim);

    always_comb begin
        phase_next = phase;
        tx_serial  = 1'b1;
        case (phase)
            ST_IDLE: begin
                if (start) phase_next = ST_START;
            end
            ST_START: begin
                tx_serial = 1'b0;
                if (tick_last) phase_next = ST_DATA;
            end
            ST_DATA: begin
                tx_serial = shreg[0];
                if (tick_last && (bit_cnt == 3'd7))
                    phase_next = (PARITY != 0) ? ST_PAR : ST_STOP;
            end
            ST_PAR: begin
                tx_serial = par_q;
                if (tick_last) phase_next = ST_STOP;
            end
            ST_STOP: begin
                if (tick_last) phase_next = start ? ST_START : ST_IDLE;
            end
            default: phase_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase   <= ST_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
        end else begin
            phase <= phase_next;
            if (load) begin
                tick    <= '0;
                bit_cnt <= '0;
                shreg   <= byte_in;
                par_q   <= ^byte_in;
            end else if (phase != ST_IDLE) begin
                tick <= tick_last ? '0 : tick + TICK_W'(1);
                if ((phase == ST_DATA) && tick_last) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/transmissor_16.sv
// rtl/transmissor_16.sv - 16-bit word serial transmitter, high byte first; TRANSMISSOR_16_DEBUG_EN drives db_estado
module transmissor_16
    import transmissor_16_pkg::*;
#(
    parameter int BAUD_RATE = 115200,
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int PARITY    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        partida,
    input  logic [15:0] data_in,
    output logic        tx_serial,
    output logic        ocupado,
    output logic        fim_transmitir,
    output logic [3:0]  db_estado
);

    localparam int TICKS = bit_ticks(CLOCK_HZ, BAUD_RATE);

    state_t     state;
    state_t     state_next;
    state_t     sub_phase_next;
    logic       low_byte;
    logic [7:0] data_lo;
    logic       accept;
    logic       sub_start;
    logic       sub_fim;
    logic [7:0] sub_byte;

    // The high byte goes straight from data_in into the sender so the start
    // bit appears on the cycle right after partida is accepted.
    assign accept    = (state == ST_IDLE) && partida;
    assign sub_start = accept || (sub_fim && !low_byte);
    assign sub_byte  = accept ? data_in[15:8] : data_lo;

    tx_serial_8 #(
        .TICKS  (TICKS),
        .PARITY (PARITY)
    ) u_tx_serial_8 (
        .clock      (clock),
        .reset      (reset),
        .start      (sub_start),
        .byte_in    (sub_byte),
        .tx_serial  (tx_serial),
        .fim        (sub_fim),
        .phase_next (sub_phase_next)
    );

    // While a byte is in flight the word FSM follows the sender's phase;
    // LOAD and NEXT each cover the first cycle of a start bit.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (partida) state_next = ST_LOAD;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                if (sub_fim) state_next = low_byte ? ST_DONE : ST_NEXT;
                else         state_next = sub_phase_next;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            low_byte <= 1'b0;
            data_lo  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                data_lo  <= data_in[7:0];
                low_byte <= 1'b0;
            end else if (sub_fim && !low_byte) begin
                low_byte <= 1'b1;
            end
        end
    end

    assign ocupado        = (state != ST_IDLE) && (state != ST_DONE);
    assign fim_transmitir = (state == ST_DONE);

`ifdef TRANSMISSOR_16_DEBUG_EN
    assign db_estado = {1'b0, state};
`else
    assign db_estado = 4'b0000;
`endif

endmodule
